// File: rtl/seven_segment_scan_pkg.sv
// Shared constants for seven-segment display blocks: dark patterns and the
// active-low {g,f,e,d,c,b,a} hex glyph table indexed by digit value.
package seg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [3:0] ANODE_OFF = 4'b1111;

  localparam logic [6:0] HEX_SEG [0:15] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

endpackage

// File: rtl/seven_segment_scan_if.sv
// Digit/control inputs and display pin outputs of the scan block.
// master = whoever feeds digits and watches the pins, slave = the scanner.
interface seven_segment_scan_if;
  logic [3:0] digit0;
  logic [3:0] digit1;
  logic [3:0] digit2;
  logic [3:0] digit3;
  logic       blank_en;
  logic [6:0] segments;
  logic       dp;
  logic [3:0] anode;

  modport master (
    output digit0, digit1, digit2, digit3, blank_en,
    input  segments, dp, anode
  );

  modport slave (
    input  digit0, digit1, digit2, digit3, blank_en,
    output segments, dp, anode
  );
endinterface

// File: rtl/seven_segment_scan_hex_to_seg.sv
// Combinational 4-bit value to active-low seven-segment glyph lookup.
module hex_to_seg
  import seg_pkg::*;
(
  input  logic [3:0] value_i,
  output logic [6:0] seg_o
);

  // Straight table lookup; every 4-bit value has a glyph.
  always_comb begin
    seg_o = HEX_SEG[value_i];
  end

endmodule

// File: rtl/seven_segment_scan.sv
// Four-digit common-anode display scanner. Digits are snapshotted once per
// frame so a frame never mixes two counter values; outputs are registered so
// anode and segments switch on the same edge.
module seven_segment_scan
  import seg_pkg::*;
#(
  parameter int REFRESH_COUNT = 100000,
  parameter int CNT_W         = 17,
  parameter int DP_DIGIT      = 2
) (
  input  logic              clk,
  input  logic              reset,
  seven_segment_scan_if.slave bus
);

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [1:0]            idx_q, idx_d;
  logic [3:0][3:0]       snap_q, snap_d;
  logic [6:0]            segments_q, segments_d;
  logic [3:0]            anode_q, anode_d;
  logic                  dp_q, dp_d;
  logic                  tick;
  logic [6:0]            glyph;
  logic                  blank_now;

  assign tick = (cnt_q == CNT_W'(REFRESH_COUNT - 1));

  hex_to_seg u_hex_to_seg (
    .value_i (snap_q[idx_q]),
    .seg_o   (glyph)
  );

  // State register: active-low synchronous reset puts the display dark.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q      <= '0;
      idx_q      <= '0;
      snap_q     <= '0;
      segments_q <= SEG_BLANK;
      anode_q    <= ANODE_OFF;
      dp_q       <= 1'b1;
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      snap_q     <= snap_d;
      segments_q <= segments_d;
      anode_q    <= anode_d;
      dp_q       <= dp_d;
    end
  end

  // Next state: refresh counter wraps, scan index steps on tick, snapshot on frame wrap.
  always_comb begin
    cnt_d  = tick ? '0 : cnt_q + CNT_W'(1);
    idx_d  = tick ? idx_q + 2'd1 : idx_q;
    snap_d = snap_q;
    if (tick && (idx_q == 2'd3)) begin
      snap_d = {bus.digit3, bus.digit2, bus.digit1, bus.digit0};
    end
  end

  // Output next value: select digit, apply leading-zero blank and decimal point.
  always_comb begin
    blank_now  = bus.blank_en && (idx_q == 2'd3) && (snap_q[3] == 4'd0) && (DP_DIGIT != 3);
    anode_d    = ~(4'b0001 << idx_q);
    segments_d = blank_now ? SEG_BLANK : glyph;
    dp_d       = (idx_q != 2'(DP_DIGIT));
  end

  assign bus.segments = segments_q;
  assign bus.anode    = anode_q;
  assign bus.dp       = dp_q;

endmodule

// File: doc/seven_segment_scan.md
# seven_segment_scan

Display-side consumer of the stopwatch's four 4-bit digit outputs. It time-multiplexes them onto a common-anode four-digit seven-segment display with a decimal point and optional leading-zero blanking. It sits between the stopwatch counter chain and the board's segment/anode pins. It snapshots the digits once per scan frame so a displayed frame never mixes two counter values.

## Interface
- REFRESH_COUNT, 100000: clk cycles each digit stays lit (1 ms at 100 MHz); must be ≥ 2.
- CNT_W, 17: width of refresh counter; must hold REFRESH_COUNT-1.
- DP_DIGIT, 2: digit position (0–3) whose decimal point is lit.
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low (0 = reset), sampled on clk.
- digit0..digit3  input  4 each  digit values, digit0 least significant; any value 0–15 is accepted.
- blank_en  input  1  1 = blank leading zero on digit3.
- segments  output  7  {g,f,e,d,c,b,a}, active-low.
- dp  output  1  decimal point, active-low.
- anode  output  4  one-hot-low digit enable; bit n selects digitn.

## Operation
- **Refresh counter `cnt`:** counts 0..REFRESH_COUNT-1 and wraps. `tick` is asserted when cnt == REFRESH_COUNT-1.
- **Scan index `idx` (2 bits):** advances 0→1→2→3→0 on `tick`. The scan states are exactly these four values.
- **Snapshot register `snap[3:0][3:0]`:** loads all four digit inputs on the edge where idx wraps 3→0 (tick && idx==3). It holds at all other times.
- **Output register:** loaded every cycle from the current (idx, snap, blank_en).
  - anode = ~(4'b0001 << idx).
  - segments = decode(snap[idx]).
  - dp = 0 only when idx == DP_DIGIT.
- **Hex decode (active-low gfedcba):**
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- **Blanking:** when blank_en=1, idx==3, snap[3]==0 and DP_DIGIT≠3, then segments=1111111. The anode is still driven. No other digit is ever blanked.
- **blank_en** is not snapshotted; it takes effect on the next output-register load.

## Timing
- **Reset (reset==0 at an edge):**
  - cnt=0, idx=0, snap=all 0.
  - anode=1111, segments=1111111, dp=1 (display dark).
- **First cycle out of reset:** the first edge with reset==1 loads the outputs for idx 0: anode=1110, segments=1000000, dp=1.
- **Output latency:** outputs lag idx/snap by exactly one clk. A digit therefore stays lit for exactly REFRESH_COUNT cycles.
- **Digit changes:** the anode and segments change on the same edge, so there is no ghost cycle with a wrong digit pattern.
- **Snapshot timing:**
  - An input change becomes visible at the start of the next frame, one cycle after the 3→0 wrap edge.
  - Maximum visibility latency is 4·REFRESH_COUNT+1 cycles.
  - An input that changes on the wrap edge itself is captured with its pre-edge value.
- **Reset mid-frame:** reset forces the dark state on that edge regardless of cnt/idx. The snapshot is discarded, so the display shows 0000 until the first wrap after reset.
- **Frame period:** 4·REFRESH_COUNT cycles.

## Structure
- **Package `seg_pkg`:**
  - SEG_BLANK = 7'b1111111.
  - ANODE_OFF = 4'b1111.
  - The 16-entry active-low hex pattern constant array, indexed by value.
- **Sub-module `hex_to_seg`:** purely combinational 4-bit → 7-bit lookup from `seg_pkg`. It is reusable by other display blocks.
- **Top level:** refresh counter, idx, snap, blank/dp mux and the output register, all in `seven_segment_scan`.

## Test plan
All scenarios use REFRESH_COUNT=4, CNT_W=2, DP_DIGIT=2.

1. **Reset:** hold reset=0 for 3 cycles, then release. Required: anode=1111, segments=1111111, dp=1 during reset. On the first edge after release: anode=1110, segments=1000000, dp=1.
2. **Scan order:** digits 3,2,1,0 present from reset. Required per frame: anode 1110/1101/1011/0111, each for 4 cycles. dp=0 only while anode=1011.
3. **Snapshot:** digit0 changes 5→7 mid-frame (idx=1). Required: digit 0 keeps showing 0010010 for the rest of the frame. It shows 1111000 starting one cycle after the 3→0 wrap.
4. **Blanking:** snap={0,4,2,9} (digit3..digit0).
   - blank_en=1: the anode 0111 slot shows 1111111.
   - blank_en=0: the same slot shows 1000000.
   - With digit3=1, the slot shows 1111001 regardless of blank_en.
5. **Hex and mid-frame reset:** digit1=4'hA. Required: slot 1101 shows 0001000. Then assert reset at idx=2, cnt=1. Required: the dark state occurs on that edge, and the display restarts at anode=1110 with all zeros.
